axi_protocol_checker: RTL and testbench
=======================================

# axi_protocol_checker

Passive, parametrised AXI3 protocol checker that snoops all five channels between the testbench BFM and the DUV and flags rule violations in hardware. It tracks outstanding write and read bursts, checks VALID/payload stability, WLAST/RLAST placement and orphan responses, and reports sticky error bits, a one-cycle error strobe and a saturating error count. It sits in `top` alongside `duv`, wired to the same nets, and drives nothing on the bus.

## Interface
Parameters:
- WIDTH, 32, address/data width; ID and LEN fields are WIDTH/8 bits
- SIZE, 3, AxSIZE width; AxBURST and xRESP are SIZE-1 bits
- DEPTH, 8, max outstanding bursts tracked per direction (power of 2, ≥2)

Ports (CW = $clog2(DEPTH+1)):
- CLOCK  in  1  sole clock, all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- CLEAR  in  1  synchronous clear of ERR, ERR_COUNT
- AWVALID, AWREADY, AWID, AWADDR, AWLEN, AWSIZE, AWBURST  in  1,1,WIDTH/8,WIDTH,WIDTH/8,SIZE,SIZE-1  write address channel
- WVALID, WREADY, WID, WDATA, WSTRB, WLAST  in  1,1,WIDTH/8,WIDTH,WIDTH/8,1  write data channel
- BVALID, BREADY, BID, BRESP  in  1,1,WIDTH/8,SIZE-1  write response channel
- ARVALID, ARREADY, ARID, ARADDR, ARLEN, ARSIZE, ARBURST  in  as AW  read address channel
- RVALID, RREADY, RID, RDATA, RRESP, RLAST  in  1,1,WIDTH/8,WIDTH,SIZE-1,1  read data channel
- ERR  out  10  sticky violation bits
- ERR_VALID  out  1  pulses when any ERR bit newly sets
- ERR_COUNT  out  16  saturating count of violation events
- WR_OUTSTANDING  out  CW  accepted AWs without B handshake
- RD_OUTSTANDING  out  CW  accepted ARs without final R beat

## Operation
- Handshake on a channel = VALID && READY at rising edge.
- Stability (bits 0–4: AW, W, AR, R, B): if previous cycle had VALID=1, READY=0, then VALID must still be 1 and all payload fields equal to registered copy; else set bit.
- Write tracking: AW handshake pushes AWLEN into write-length FIFO (DEPTH). W beat counter counts W handshakes against FIFO head; beat number AWLEN+1 must carry WLAST=1, earlier beats WLAST=0, else bit 5; on the last beat FIFO pops and counter clears.
- Read tracking: AR handshake pushes ARLEN into read FIFO; R beats checked against head identically (RLAST placement, bit 6). Read data returns in AR order.
- Orphans (bit 7): W beat with write FIFO empty and no same-cycle AW handshake; R beat with read FIFO empty and no same-cycle AR; B handshake with zero completed-unacknowledged writes.
- Overflow (bit 8): push into full FIFO; push dropped, state otherwise unchanged.
- Completed-write credit: +1 on WLAST beat accepted, −1 on B handshake; both same cycle → unchanged.
- ERR_COUNT += number of violation events detected that cycle (one per bit set that cycle), saturating at 16'hFFFF.

## Timing
- RESET low: ERR=0, ERR_VALID=0, ERR_COUNT=0, WR/RD_OUTSTANDING=0, FIFOs empty, beat counters 0, stability history cleared; takes effect immediately, mid-burst state discarded.
- Detection at edge N → ERR bit, ERR_VALID, ERR_COUNT visible after edge N (registered, 1-cycle latency from offending sample).
- Same-cycle AW handshake and W beat into empty FIFO: bypass, AWLEN used directly; single-beat burst (LEN=0) with WLAST pushes nothing.
- Same-cycle push and pop on full FIFO: legal, no overflow.
- CLEAR and new violation same cycle: new violation wins (bit set, count = 1).
- WR_OUTSTANDING increments on AW, decrements on B; RD_OUTSTANDING decrements on RLAST beat.

## Configuration
- AXI_CHK_RESP_EN defined: bit 9 set when a B handshake has BRESP ≥ 2 or an R beat has RRESP ≥ 2 (SLVERR/DECERR); counted in ERR_COUNT.
- Undefined: ERR[9] tied 0, response values ignored.

## Test plan
- AW AWLEN=3, four W beats WLAST on 4th, B OKAY → ERR=0, WR_OUTSTANDING 1→0 after B.
- AWVALID=1, AWREADY=0, AWADDR changes 0x100→0x104 next cycle → ERR[0]=1, ERR_VALID one cycle, ERR_COUNT=1.
- AR ARLEN=1, RLAST on first beat → ERR[6]=1; second AR ARLEN=0 then checks clean.
- BVALID/BREADY with no write issued after reset → ERR[7]=1; RESET low mid-burst → all outputs 0.
- DEPTH+1 ARs without R beats → ERR[8]=1, RD_OUTSTANDING=DEPTH.
- With AXI_CHK_RESP_EN, B with BRESP=2'b10 → ERR[9]=1; without, ERR=0.

Source files
------------

// File: rtl/axi_protocol_checker.sv
// axi_protocol_checker: passive AXI3 rule checker snooping all five channels.
// Define AXI_CHK_RESP_EN to flag SLVERR/DECERR responses on ERR[9].
module axi_protocol_checker #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 3,
    parameter int DEPTH = 8,
    localparam int IW   = WIDTH / 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              CLEAR,
    input  logic              AWVALID,
    input  logic              AWREADY,
    input  logic [IW-1:0]     AWID,
    input  logic [WIDTH-1:0]  AWADDR,
    input  logic [IW-1:0]     AWLEN,
    input  logic [SIZE-1:0]   AWSIZE,
    input  logic [SIZE-2:0]   AWBURST,
    input  logic              WVALID,
    input  logic              WREADY,
    input  logic [IW-1:0]     WID,
    input  logic [WIDTH-1:0]  WDATA,
    input  logic [IW-1:0]     WSTRB,
    input  logic              WLAST,
    input  logic              BVALID,
    input  logic              BREADY,
    input  logic [IW-1:0]     BID,
    input  logic [SIZE-2:0]   BRESP,
    input  logic              ARVALID,
    input  logic              ARREADY,
    input  logic [IW-1:0]     ARID,
    input  logic [WIDTH-1:0]  ARADDR,
    input  logic [IW-1:0]     ARLEN,
    input  logic [SIZE-1:0]   ARSIZE,
    input  logic [SIZE-2:0]   ARBURST,
    input  logic              RVALID,
    input  logic              RREADY,
    input  logic [IW-1:0]     RID,
    input  logic [WIDTH-1:0]  RDATA,
    input  logic [SIZE-2:0]   RRESP,
    input  logic              RLAST,
    output logic [9:0]        ERR,
    output logic              ERR_VALID,
    output logic [15:0]       ERR_COUNT,
    output logic [CW-1:0]     WR_OUTSTANDING,
    output logic [CW-1:0]     RD_OUTSTANDING
);
    localparam int PW  = $clog2(DEPTH);
    localparam int RW  = SIZE - 1;
    localparam int AXW = 2 * IW + WIDTH + SIZE + RW;
    localparam int WPW = 2 * IW + WIDTH + 1;
    localparam int RPW = IW + WIDTH + RW + 1;
    localparam int BPW = IW + RW;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign b_hs  = BVALID && BREADY;
    assign ar_hs = ARVALID && ARREADY;
    assign r_hs  = RVALID && RREADY;

    logic [AXW-1:0] aw_pl, aw_q, ar_pl, ar_q;
    logic [WPW-1:0] w_pl, w_q;
    logic [RPW-1:0] r_pl, r_q;
    logic [BPW-1:0] b_pl, b_q;
    logic [4:0]     stall_q, stab;
    assign aw_pl = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST};
    assign ar_pl = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
    assign w_pl  = {WID, WDATA, WSTRB, WLAST};
    assign r_pl  = {RID, RDATA, RRESP, RLAST};
    assign b_pl  = {BID, BRESP};

    // a stalled channel must keep VALID high and its payload frozen
    always_comb begin
        stab    = '0;
        stab[0] = stall_q[0] && (!AWVALID || aw_pl != aw_q);
        stab[1] = stall_q[1] && (!WVALID || w_pl != w_q);
        stab[2] = stall_q[2] && (!ARVALID || ar_pl != ar_q);
        stab[3] = stall_q[3] && (!RVALID || r_pl != r_q);
        stab[4] = stall_q[4] && (!BVALID || b_pl != b_q);
    end

    // remember which channels were stalled and what they carried
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            stall_q <= '0;
            aw_q    <= '0;
            ar_q    <= '0;
            w_q     <= '0;
            r_q     <= '0;
            b_q     <= '0;
        end else begin
            stall_q <= {BVALID && !BREADY, RVALID && !RREADY,
                        ARVALID && !ARREADY, WVALID && !WREADY,
                        AWVALID && !AWREADY};
            aw_q    <= aw_pl;
            ar_q    <= ar_pl;
            w_q     <= w_pl;
            r_q     <= r_pl;
            b_q     <= b_pl;
        end
    end

    logic [IW-1:0] wf_mem [DEPTH];
    logic [IW-1:0] rf_mem [DEPTH];
    logic [PW-1:0] wf_wp, wf_rp, rf_wp, rf_rp;
    logic [CW-1:0] wf_cnt, rf_cnt;
    logic [IW-1:0] w_beat, r_beat, w_len, r_len;
    logic w_have, w_end, w_pop, w_push, w_orph, w_lerr, w_ovf;
    logic r_have, r_end, r_pop, r_push, r_orph, r_lerr, r_ovf;

    // an empty FIFO falls back to the same-cycle address beat
    assign w_len  = (wf_cnt == '0) ? AWLEN : wf_mem[wf_rp];
    assign w_have = (wf_cnt != '0) || aw_hs;
    assign w_end  = w_beat == w_len;
    assign w_pop  = w_hs && w_have && w_end;
    assign w_orph = w_hs && !w_have;
    assign w_lerr = w_hs && w_have && (WLAST != w_end);
    assign w_ovf  = aw_hs && wf_cnt == CW'(DEPTH) && !w_pop;
    assign w_push = aw_hs && !w_ovf;

    assign r_len  = (rf_cnt == '0) ? ARLEN : rf_mem[rf_rp];
    assign r_have = (rf_cnt != '0) || ar_hs;
    assign r_end  = r_beat == r_len;
    assign r_pop  = r_hs && r_have && r_end;
    assign r_orph = r_hs && !r_have;
    assign r_lerr = r_hs && r_have && (RLAST != r_end);
    assign r_ovf  = ar_hs && rf_cnt == CW'(DEPTH) && !r_pop;
    assign r_push = ar_hs && !r_ovf;

    // burst length storage, no reset needed behind the pointers
    always_ff @(posedge CLOCK) begin
        if (w_push) wf_mem[wf_wp] <= AWLEN;
        if (r_push) rf_mem[rf_wp] <= ARLEN;
    end

    // FIFO pointers, occupancy and beat counters for both directions
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            wf_wp  <= '0;
            wf_rp  <= '0;
            wf_cnt <= '0;
            w_beat <= '0;
            rf_wp  <= '0;
            rf_rp  <= '0;
            rf_cnt <= '0;
            r_beat <= '0;
        end else begin
            if (w_push) wf_wp <= wf_wp + 1'b1;
            if (w_pop)  wf_rp <= wf_rp + 1'b1;
            if (w_push && !w_pop)      wf_cnt <= wf_cnt + 1'b1;
            else if (w_pop && !w_push) wf_cnt <= wf_cnt - 1'b1;
            if (w_pop)                 w_beat <= '0;
            else if (w_hs && w_have)   w_beat <= w_beat + 1'b1;
            if (r_push) rf_wp <= rf_wp + 1'b1;
            if (r_pop)  rf_rp <= rf_rp + 1'b1;
            if (r_push && !r_pop)      rf_cnt <= rf_cnt + 1'b1;
            else if (r_pop && !r_push) rf_cnt <= rf_cnt - 1'b1;
            if (r_pop)                 r_beat <= '0;
            else if (r_hs && r_have)   r_beat <= r_beat + 1'b1;
        end
    end

    logic [CW-1:0] credit, wr_out;
    logic w_done, b_orph, wr_dec;
    assign w_done = w_hs && WLAST;
    assign b_orph = b_hs && credit == '0 && !w_done;
    assign wr_dec = b_hs && wr_out != '0;
    assign WR_OUTSTANDING = wr_out;
    assign RD_OUTSTANDING = rf_cnt;

    // completed-write credit and outstanding write count
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            credit <= '0;
            wr_out <= '0;
        end else begin
            if (w_done && !b_hs && credit != '1)
                credit <= credit + 1'b1;
            else if (b_hs && !w_done && credit != '0)
                credit <= credit - 1'b1;
            if (w_push && !wr_dec && wr_out != '1)
                wr_out <= wr_out + 1'b1;
            else if (wr_dec && !w_push)
                wr_out <= wr_out - 1'b1;
        end
    end

    logic [9:0]  ev, err_base;
    logic [15:0] cnt_base;
    logic [16:0] sum;

    // gather this cycle's violation events, one bit per class
    always_comb begin
        ev      = '0;
        ev[4:0] = stab;
        ev[5]   = w_lerr;
        ev[6]   = r_lerr;
        ev[7]   = w_orph || r_orph || b_orph;
        ev[8]   = w_ovf || r_ovf;
`ifdef AXI_CHK_RESP_EN
        ev[9]   = (b_hs && 32'(BRESP) >= 32'd2) ||
                  (r_hs && 32'(RRESP) >= 32'd2);
`endif
    end

    assign err_base = CLEAR ? '0 : ERR;
    assign cnt_base = CLEAR ? '0 : ERR_COUNT;
    assign sum      = {1'b0, cnt_base} + 17'($countones(ev));

    // sticky bits, new-bit strobe and saturating event count
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            ERR       <= '0;
            ERR_VALID <= 1'b0;
            ERR_COUNT <= '0;
        end else begin
            ERR       <= err_base | ev;
            ERR_VALID <= |(ev & ~err_base);
            ERR_COUNT <= sum[16] ? 16'hFFFF : sum[15:0];
        end
    end
endmodule

// File: tb/tb_axi_protocol_checker.sv
// tb_axi_protocol_checker: directed and random traffic against a
// queue-based reference model of the AXI protocol checker.
module tb_axi_protocol_checker;
    localparam int WIDTH = 32;
    localparam int SIZE  = 3;
    localparam int DEPTH = 8;
    localparam int IW    = WIDTH / 8;
    localparam int RW    = SIZE - 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int CMAX  = (1 << CW) - 1;
    localparam int AXW   = 2 * IW + WIDTH + SIZE + RW;
    localparam int WPW   = 2 * IW + WIDTH + 1;
    localparam int RPW   = IW + WIDTH + RW + 1;
    localparam int BPW   = IW + RW;
`ifdef AXI_CHK_RESP_EN
    localparam int RESP_ERR = 'h200;
`else
    localparam int RESP_ERR = 0;
`endif

    logic CLOCK, RESET, CLEAR;
    logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic ARVALID, ARREADY, RVALID, RREADY, WLAST, RLAST;
    logic [IW-1:0] AWID, AWLEN, WID, WSTRB, BID, ARID, ARLEN, RID;
    logic [WIDTH-1:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [SIZE-1:0] AWSIZE, ARSIZE;
    logic [RW-1:0] AWBURST, BRESP, ARBURST, RRESP;
    logic [9:0] ERR;
    logic ERR_VALID;
    logic [15:0] ERR_COUNT;
    logic [CW-1:0] WR_OUTSTANDING, RD_OUTSTANDING;

    axi_protocol_checker #(.WIDTH(WIDTH), .SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .CLEAR(CLEAR),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WID(WID), .WDATA(WDATA),
        .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST),
        .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA),
        .RRESP(RRESP), .RLAST(RLAST),
        .ERR(ERR), .ERR_VALID(ERR_VALID), .ERR_COUNT(ERR_COUNT),
        .WR_OUTSTANDING(WR_OUTSTANDING), .RD_OUTSTANDING(RD_OUTSTANDING)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    // reference model state
    int wq[$];
    int rq[$];
    int m_wbeat, m_rbeat, m_credit, m_wrout, m_cnt;
    bit [9:0] m_err;
    bit m_val;
    bit [4:0] p_stall;
    logic [AXW-1:0] p_aw, p_ar;
    logic [WPW-1:0] p_w;
    logic [RPW-1:0] p_r;
    logic [BPW-1:0] p_b;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic model_step();
        bit [9:0] ev;
        bit [9:0] base_err;
        bit aw, w, b, ar, r, wpop, rpop, awo, aro, wdone, inc, dec;
        int sz, len, base_cnt;
        if (!RESET) begin
            wq.delete();
            rq.delete();
            m_wbeat = 0; m_rbeat = 0; m_credit = 0; m_wrout = 0;
            m_err = '0; m_val = 0; m_cnt = 0; p_stall = '0;
            return;
        end
        ev = '0; wpop = 0; rpop = 0; awo = 0; aro = 0;
        aw = AWVALID && AWREADY;
        w  = WVALID && WREADY;
        b  = BVALID && BREADY;
        ar = ARVALID && ARREADY;
        r  = RVALID && RREADY;
        if (p_stall[0] && (!AWVALID ||
            {AWID, AWADDR, AWLEN, AWSIZE, AWBURST} != p_aw)) ev[0] = 1;
        if (p_stall[1] && (!WVALID ||
            {WID, WDATA, WSTRB, WLAST} != p_w)) ev[1] = 1;
        if (p_stall[2] && (!ARVALID ||
            {ARID, ARADDR, ARLEN, ARSIZE, ARBURST} != p_ar)) ev[2] = 1;
        if (p_stall[3] && (!RVALID ||
            {RID, RDATA, RRESP, RLAST} != p_r)) ev[3] = 1;
        if (p_stall[4] && (!BVALID || {BID, BRESP} != p_b)) ev[4] = 1;
        if (w) begin
            if (wq.size() == 0 && !aw) ev[7] = 1;
            else begin
                len = (wq.size() != 0) ? wq[0] : int'(AWLEN);
                if (WLAST != (m_wbeat == len)) ev[5] = 1;
                if (m_wbeat == len) begin wpop = 1; m_wbeat = 0; end
                else m_wbeat++;
            end
        end
        sz = wq.size();
        if (wpop && sz > 0) void'(wq.pop_front());
        if (aw) begin
            if (sz == DEPTH && !wpop) begin ev[8] = 1; awo = 1; end
            else if (!(wpop && sz == 0)) wq.push_back(int'(AWLEN));
        end
        if (r) begin
            if (rq.size() == 0 && !ar) ev[7] = 1;
            else begin
                len = (rq.size() != 0) ? rq[0] : int'(ARLEN);
                if (RLAST != (m_rbeat == len)) ev[6] = 1;
                if (m_rbeat == len) begin rpop = 1; m_rbeat = 0; end
                else m_rbeat++;
            end
        end
        sz = rq.size();
        if (rpop && sz > 0) void'(rq.pop_front());
        if (ar) begin
            if (sz == DEPTH && !rpop) begin ev[8] = 1; aro = 1; end
            else if (!(rpop && sz == 0)) rq.push_back(int'(ARLEN));
        end
        wdone = w && WLAST;
        if (b && m_credit == 0 && !wdone) ev[7] = 1;
        if (wdone && !b && m_credit < CMAX) m_credit++;
        else if (b && !wdone && m_credit > 0) m_credit--;
        inc = aw && !awo;
        dec = b && m_wrout > 0;
        m_wrout = m_wrout + int'(inc) - int'(dec);
        if (m_wrout > CMAX) m_wrout = CMAX;
`ifdef AXI_CHK_RESP_EN
        if ((b && BRESP >= 2'd2) || (r && RRESP >= 2'd2)) ev[9] = 1;
`endif
        base_err = CLEAR ? 10'd0 : m_err;
        base_cnt = CLEAR ? 0 : m_cnt;
        m_val = |(ev & ~base_err);
        m_err = base_err | ev;
        m_cnt = base_cnt + $countones(ev);
        if (m_cnt > 65535) m_cnt = 65535;
        p_stall = {BVALID && !BREADY, RVALID && !RREADY,
                   ARVALID && !ARREADY, WVALID && !WREADY,
                   AWVALID && !AWREADY};
        p_aw = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST};
        p_ar = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
        p_w  = {WID, WDATA, WSTRB, WLAST};
        p_r  = {RID, RDATA, RRESP, RLAST};
        p_b  = {BID, BRESP};
    endtask

    // model advances on each edge, outputs compared just after it
    always begin
        @(posedge CLOCK);
        model_step();
        #1;
        if (chk_en) begin
            chk("err", int'(ERR), int'(m_err));
            chk("err_valid", int'(ERR_VALID), int'(m_val));
            chk("err_count", int'(ERR_COUNT), m_cnt);
            chk("wr_out", int'(WR_OUTSTANDING), m_wrout);
            chk("rd_out", int'(RD_OUTSTANDING), rq.size());
        end
    end

    task automatic step();
        @(negedge CLOCK);
    endtask

    task automatic idle();
        CLEAR = 0;
        AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0;
        BVALID = 0; BREADY = 0; ARVALID = 0; ARREADY = 0;
        RVALID = 0; RREADY = 0; WLAST = 0; RLAST = 0;
        BRESP = '0; RRESP = '0;
    endtask

    task automatic clear_pulse();
        step(); idle(); CLEAR = 1;
        step(); CLEAR = 0;
    endtask

    task automatic rand_cycle();
        bit e;
        step();
        if (!(AWVALID && !AWREADY) || $urandom_range(0, 49) == 0) begin
            AWVALID = ($urandom_range(0, 3) == 0);
            AWID = IW'($urandom); AWADDR = $urandom;
            AWLEN = IW'($urandom_range(0, 3));
            AWSIZE = SIZE'($urandom); AWBURST = RW'($urandom);
        end
        AWREADY = 1'($urandom_range(0, 1));
        if (!(WVALID && !WREADY) || $urandom_range(0, 49) == 0) begin
            WVALID = ($urandom_range(0, 2) == 0);
            WID = IW'($urandom); WDATA = $urandom; WSTRB = IW'($urandom);
            e = (wq.size() != 0) ? (m_wbeat == wq[0]) : (AWLEN == 0);
            WLAST = ($urandom_range(0, 9) != 0) ? e : 1'($urandom);
        end
        WREADY = 1'($urandom_range(0, 1));
        if (!(BVALID && !BREADY) || $urandom_range(0, 49) == 0) begin
            BVALID = ($urandom_range(0, 4) == 0);
            BID = IW'($urandom);
            BRESP = ($urandom_range(0, 7) == 0) ? RW'($urandom) : '0;
        end
        BREADY = 1'($urandom_range(0, 1));
        if (!(ARVALID && !ARREADY) || $urandom_range(0, 49) == 0) begin
            ARVALID = ($urandom_range(0, 3) == 0);
            ARID = IW'($urandom); ARADDR = $urandom;
            ARLEN = IW'($urandom_range(0, 3));
            ARSIZE = SIZE'($urandom); ARBURST = RW'($urandom);
        end
        ARREADY = 1'($urandom_range(0, 1));
        if (!(RVALID && !RREADY) || $urandom_range(0, 49) == 0) begin
            RVALID = ($urandom_range(0, 1) == 0);
            RID = IW'($urandom); RDATA = $urandom;
            RRESP = ($urandom_range(0, 7) == 0) ? RW'($urandom) : '0;
            e = (rq.size() != 0) ? (m_rbeat == rq[0]) : (ARLEN == 0);
            RLAST = ($urandom_range(0, 9) != 0) ? e : 1'($urandom);
        end
        RREADY = 1'($urandom_range(0, 1));
        CLEAR = ($urandom_range(0, 31) == 0);
    endtask

    initial begin
        RESET = 0;
        idle();
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
        WID = '0; WDATA = '0; WSTRB = '0; BID = '0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
        RID = '0; RDATA = '0;
        repeat (3) step();
        chk("rst_err", int'(ERR), 0);
        chk("rst_valid", int'(ERR_VALID), 0);
        chk("rst_count", int'(ERR_COUNT), 0);
        chk("rst_wr", int'(WR_OUTSTANDING), 0);
        chk("rst_rd", int'(RD_OUTSTANDING), 0);
        RESET = 1;
        chk_en = 1;

        // clean 4-beat write
        step(); AWVALID = 1; AWREADY = 1; AWLEN = 4'd3;
        step(); AWVALID = 0; AWREADY = 0;
        chk("t1_wr1", int'(WR_OUTSTANDING), 1);
        for (int i = 0; i < 4; i++) begin
            WVALID = 1; WREADY = 1; WLAST = (i == 3);
            step();
        end
        idle(); BVALID = 1; BREADY = 1;
        step(); idle();
        chk("t1_wr0", int'(WR_OUTSTANDING), 0);
        chk("t1_err", int'(ERR), 0);

        // address changes while stalled
        AWVALID = 1; AWREADY = 0; AWADDR = 32'h100; AWLEN = '0;
        step(); AWADDR = 32'h104;
        step();
        chk("t2_err", int'(ERR), 'h001);
        chk("t2_valid", int'(ERR_VALID), 1);
        chk("t2_count", int'(ERR_COUNT), 1);
        AWREADY = 1;
        step(); idle();
        chk("t2_pulse", int'(ERR_VALID), 0);
        chk("t2_count1", int'(ERR_COUNT), 1);
        WVALID = 1; WREADY = 1; WLAST = 1;
        step(); idle(); BVALID = 1; BREADY = 1;
        clear_pulse();
        step();
        chk("t2_clr_err", int'(ERR), 0);
        chk("t2_clr_cnt", int'(ERR_COUNT), 0);

        // early RLAST, then the stream resynchronises
        ARVALID = 1; ARREADY = 1; ARLEN = 4'd1;
        step(); idle(); RVALID = 1; RREADY = 1; RLAST = 1;
        step(); idle();
        chk("t3_err", int'(ERR), 'h040);
        chk("t3_rd1", int'(RD_OUTSTANDING), 1);
        ARVALID = 1; ARREADY = 1; ARLEN = '0;
        step(); idle();
        chk("t3_rd2", int'(RD_OUTSTANDING), 2);
        RVALID = 1; RREADY = 1; RLAST = 1;
        step(); step(); idle();
        chk("t3_err2", int'(ERR), 'h040);
        chk("t3_cnt", int'(ERR_COUNT), 1);
        chk("t3_rd0", int'(RD_OUTSTANDING), 0);
        clear_pulse();

        // orphan B, then reset in the middle of a burst
        BVALID = 1; BREADY = 1;
        step(); idle();
        chk("t4_err", int'(ERR), 'h080);
        AWVALID = 1; AWREADY = 1; AWLEN = 4'd3;
        step(); idle(); WVALID = 1; WREADY = 1;
        step(); step(); idle(); RESET = 0;
        #1;
        chk("t4_rst_err", int'(ERR), 0);
        chk("t4_rst_cnt", int'(ERR_COUNT), 0);
        chk("t4_rst_wr", int'(WR_OUTSTANDING), 0);
        step(); RESET = 1;

        // read FIFO overflow, then push+pop on a full FIFO
        ARVALID = 1; ARREADY = 1; ARLEN = '0;
        repeat (DEPTH + 1) step();
        idle();
        chk("t5_err", int'(ERR), 'h100);
        chk("t5_rd", int'(RD_OUTSTANDING), DEPTH);
        chk("t5_cnt", int'(ERR_COUNT), 1);
        ARVALID = 1; ARREADY = 1; RVALID = 1; RREADY = 1; RLAST = 1;
        step(); idle();
        chk("t5_full_pp", int'(RD_OUTSTANDING), DEPTH);
        RVALID = 1; RREADY = 1; RLAST = 1;
        repeat (DEPTH) step();
        idle();
        chk("t5_rd0", int'(RD_OUTSTANDING), 0);
        chk("t5_cnt1", int'(ERR_COUNT), 1);
        clear_pulse();

        // same-cycle AW and single W beat, then error response
        AWVALID = 1; AWREADY = 1; AWLEN = '0;
        WVALID = 1; WREADY = 1; WLAST = 1;
        step(); idle();
        chk("t6_wr1", int'(WR_OUTSTANDING), 1);
        chk("t6_err0", int'(ERR), 0);
        BVALID = 1; BREADY = 1; BRESP = 2'b10;
        step(); idle();
        chk("t6_resp", int'(ERR), RESP_ERR);
        chk("t6_wr0", int'(WR_OUTSTANDING), 0);
        CLEAR = 1; BVALID = 1; BREADY = 1;
        step(); idle();
        chk("t6_clr_err", int'(ERR), 'h080);
        chk("t6_clr_cnt", int'(ERR_COUNT), 1);
        chk("t6_clr_val", int'(ERR_VALID), 1);

        // random traffic with one reset in the middle
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                step(); idle(); RESET = 0;
                step(); step(); RESET = 1;
            end else begin
                rand_cycle();
            end
        end
        step(); idle();
        step(); step();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
